times_table_axi_reader: RTL and testbench

//  AXI4-Lite read master between the times-table requester and the BRAM/AXI

---
 rtl/times_table_axi_reader_pkg.sv | 27 ++
 rtl/times_table_axi_reader_if.sv | 24 ++
 rtl/times_table_axi_reader.sv | 107 ++++++++++
 tb/tb_times_table_axi_reader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/times_table_axi_reader_pkg.sv
// Shared types and constants for the times-table AXI4-Lite read master.
package times_table_axi_reader_pkg;

    // Width of the ADDR+DATA timeout counter
    localparam int unsigned TO_W = 8;

    // AXI read response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Default byte base address of the product table
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    // Read-transaction sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/times_table_axi_reader_if.sv
// AXI4-Lite read-only channel bundle (AR + R).
interface times_table_axi_reader_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/times_table_axi_reader.sv
// Reads one product from a preloaded 8x8 table over AXI4-Lite per request.
module times_table_axi_reader
    import times_table_axi_reader_pkg::*;
#(
    parameter int unsigned     OP_W      = 3,
    parameter int unsigned     ADDR_W    = 32,
    parameter int unsigned     DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter logic [TO_W-1:0] TIMEOUT   = 8'd255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic                read,
    output logic [2*OP_W-1:0]   result,
    output logic                result_valid,
    output logic                busy,
    output logic                err,
    times_table_axi_reader_if.master m_axi
);

    state_t          state;
    state_t          state_n;
    logic [TO_W-1:0] to_cnt;
    logic            accept;
    logic            ar_hs;
    logic            r_hs;
    logic            in_flight;
    logic            unused_rdata_hi;

    assign accept    = (state == ST_IDLE) && read;
    assign ar_hs     = m_axi.arvalid && m_axi.arready;
    assign r_hs      = m_axi.rvalid && m_axi.rready;
    assign in_flight = (state == ST_ADDR) || (state == ST_DATA);

    assign m_axi.arprot  = AXI_PROT_DEFAULT;
    assign unused_rdata_hi = ^m_axi.rdata[DATA_W-1:2*OP_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (read)  state_n = ST_ADDR;
            ST_ADDR: if (ar_hs) state_n = ST_DATA;
            ST_DATA: if (r_hs)  state_n = ST_DONE;
            ST_DONE:            state_n = ST_IDLE;
            default:            state_n = ST_IDLE;
        endcase
    end

    // Registered handshake/status outputs, address and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            m_axi.araddr  <= '0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            result        <= '0;
        end else begin
            m_axi.arvalid <= (state_n == ST_ADDR);
            m_axi.rready  <= (state_n == ST_DATA);
            busy          <= (state_n != ST_IDLE);
            result_valid  <= (state_n == ST_DONE);
            if (accept) begin
                m_axi.araddr <= BASE_ADDR + (ADDR_W'({a, b}) << 2);
            end
            if (r_hs) begin
                result <= m_axi.rdata[2*OP_W-1:0];
            end
        end
    end

    // Sticky error: bad response or saturating wait timeout; cleared per request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else if (in_flight) begin
            if (to_cnt != TIMEOUT) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TIMEOUT - TO_W'(1)) begin
                    err <= 1'b1;
                end
            end else begin
                err <= 1'b1;
            end
            if (r_hs && (m_axi.rresp != AXI_RESP_OKAY)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_times_table_axi_reader.sv
// Directed bench for times_table_axi_reader with a delay-configurable AXI slave.
module tb_times_table_axi_reader;
    import times_table_axi_reader_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a;
    logic [2:0] b;
    logic       read;
    logic [5:0] result;
    logic       result_valid;
    logic       busy;
    logic       err;

    times_table_axi_reader_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    times_table_axi_reader dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .read         (read),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err),
        .m_axi        (axi)
    );

    always #5 clk = ~clk;

    int nassert = 0;
    int nfail   = 0;

    // Slave configuration (written by main only)
    int         ar_delay = 0;
    int         r_delay  = 0;
    logic [1:0] resp_cfg = 2'b00;

    // Slave observations (written by slave only)
    int          ar_count = 0;
    logic [31:0] last_araddr = 32'h0;

    // Monitor observations (written by monitor only)
    int         rv_count = 0;
    logic [5:0] last_result = 6'h0;
    logic       last_err = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [5:0]  res;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // AXI slave model: table of products with junk in the upper data bits
    initial begin : slave
        int          ar_cnt;
        int          r_cnt;
        bit          pending;
        bit          ar_hs;
        bit          r_hs;
        logic [31:0] hs_addr;
        logic [31:0] cur_addr;
        logic [5:0]  idx;
        logic [5:0]  prod;
        ar_cnt = 0; r_cnt = 0; pending = 0; ar_hs = 0; r_hs = 0;
        hs_addr = 32'h0; cur_addr = 32'h0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                ar_cnt = 0; r_cnt = 0; pending = 0; ar_hs = 0; r_hs = 0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                continue;
            end
            if (ar_hs) begin
                pending     = 1;
                r_cnt       = 0;
                cur_addr    = hs_addr;
                ar_count    = ar_count + 1;
                last_araddr = hs_addr;
            end
            if (r_hs) pending = 0;
            if (axi.arvalid && !pending) begin
                axi.arready = (ar_cnt >= ar_delay);
                ar_cnt      = ar_cnt + 1;
            end else begin
                axi.arready = 1'b0;
                ar_cnt      = 0;
            end
            if (pending) begin
                idx        = 6'(cur_addr >> 2);
                prod       = 6'(idx[5:3]) * 6'(idx[2:0]);
                axi.rvalid = (r_cnt >= r_delay);
                axi.rdata  = 32'hDEAD_BEC0 | 32'(prod);
                axi.rresp  = resp_cfg;
                r_cnt      = r_cnt + 1;
            end else begin
                axi.rvalid = 1'b0;
            end
            ar_hs   = axi.arvalid && axi.arready;
            hs_addr = axi.araddr;
            r_hs    = axi.rvalid && axi.rready;
        end
    end

    // Result pulse monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                rv_count    = rv_count + 1;
                last_result = result;
                last_err    = err;
            end
        end
    end

    // Overall time limit
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        nassert = nassert + 1;
        assert (got === expv) else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic issue(input logic [2:0] ia, input logic [2:0] ib, input logic eerr);
        exp_t       e;
        logic [5:0] ab;
        @(negedge clk);
        a    = ia;
        b    = ib;
        read = 1'b1;
        ab     = {ia, ib};
        e.addr = 32'(ab) << 2;
        e.res  = 6'(ia) * 6'(ib);
        e.err  = eerr;
        sb.push_back(e);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wait_rv(input string tag, input int budget);
        int n;
        n = 0;
        while (!result_valid && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic sb_check(input string tag, input logic [5:0] res,
                            input logic oerr, input logic [31:0] addr);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_result"}, 32'(res), 32'(e.res));
        chk({tag, "_err"}, 32'(oerr), 32'(e.err));
        chk({tag, "_araddr"}, addr, e.addr);
    endtask

    initial begin : main
        int  ar0;
        int  rv0;
        int  n;
        bit  stable;

        rst = 1'b1; read = 1'b0; a = 3'd0; b = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst_rready", 32'(axi.rready), 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Minimum latency, always-ready slave
        issue(3'd3, 3'd7, 1'b0);
        chk("lat_arvalid_n1", 32'(axi.arvalid), 32'd1);
        chk("lat_busy_n1", 32'(busy), 32'd1);
        chk("lat_araddr_n1", axi.araddr, 32'h7C);
        @(negedge clk);
        chk("lat_rready_n2", 32'(axi.rready), 32'd1);
        chk("lat_arvalid_n2", 32'(axi.arvalid), 32'd0);
        @(negedge clk);
        chk("lat_rvalid_n3", 32'(result_valid), 32'd1);
        sb_check("lat", result, err, last_araddr);
        @(negedge clk);
        chk("lat_pulse_end", 32'(result_valid), 32'd0);
        chk("lat_busy_end", 32'(busy), 32'd0);

        // Delayed handshakes: address must hold while arvalid
        ar_delay = 5; r_delay = 4;
        ar0 = ar_count; rv0 = rv_count;
        issue(3'd7, 3'd7, 1'b0);
        stable = 1; n = 0;
        while (!result_valid && n < 100) begin
            if (axi.arvalid && axi.araddr !== 32'hFC) stable = 0;
            @(negedge clk);
            n = n + 1;
        end
        chk("dly_addr_stable", 32'(stable), 32'd1);
        chk("dly_rv", 32'(result_valid), 32'd1);
        sb_check("dly", result, err, last_araddr);
        repeat (3) @(negedge clk);
        chk("dly_one_pulse", 32'(rv_count - rv0), 32'd1);
        chk("dly_one_ar", 32'(ar_count - ar0), 32'd1);

        // Read held high: re-accepted only when back in IDLE
        ar_delay = 0; r_delay = 0;
        wait_idle("hold_pre");
        ar0 = ar_count; rv0 = rv_count;
        @(negedge clk);
        a = 3'd6; b = 3'd5; read = 1'b1;
        repeat (10) @(negedge clk);
        read = 1'b0;
        wait_idle("hold");
        repeat (2) @(negedge clk);
        chk("hold_ar_count", 32'(ar_count - ar0), 32'd3);
        chk("hold_rv_count", 32'(rv_count - rv0), 32'd3);
        chk("hold_result", 32'(last_result), 32'd30);

        // Requests and operand changes while busy are ignored
        ar0 = ar_count;
        issue(3'd0, 3'd5, 1'b0);
        a = 3'd2; b = 3'd2; read = 1'b1;
        repeat (3) @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        chk("busy_ign_ar", 32'(ar_count - ar0), 32'd1);
        chk("busy_ign_idle", 32'(busy), 32'd0);
        sb_check("b2b_first", last_result, last_err, last_araddr);
        issue(3'd2, 3'd2, 1'b0);
        wait_rv("b2b_second", 50);
        sb_check("b2b_second", result, err, last_araddr);

        // Error response still latches data; next request clears err
        resp_cfg = AXI_RESP_SLVERR;
        issue(3'd3, 3'd7, 1'b1);
        wait_rv("slverr", 50);
        sb_check("slverr", result, err, last_araddr);
        resp_cfg = AXI_RESP_OKAY;
        issue(3'd1, 3'd1, 1'b0);
        chk("slverr_clear", 32'(err), 32'd0);
        wait_rv("after_err", 50);
        sb_check("after_err", result, err, last_araddr);

        // Timeout flags err without aborting the transaction
        ar_delay = 300;
        issue(3'd2, 3'd3, 1'b1);
        repeat (199) @(negedge clk);
        chk("to_err_early", 32'(err), 32'd0);
        chk("to_arvalid_early", 32'(axi.arvalid), 32'd1);
        repeat (60) @(negedge clk);
        chk("to_err_set", 32'(err), 32'd1);
        chk("to_arvalid_held", 32'(axi.arvalid), 32'd1);
        wait_rv("to", 1000);
        sb_check("to", result, err, last_araddr);
        @(negedge clk);
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a transaction
        ar_delay = 3;
        issue(3'd4, 3'd4, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_arvalid", 32'(axi.arvalid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rready", 32'(axi.rready), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_araddr", axi.araddr, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ar_delay = 0;
        repeat (2) @(negedge clk);
        issue(3'd5, 3'd6, 1'b0);
        wait_rv("post_rst", 50);
        sb_check("post_rst", result, err, last_araddr);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
